grid_sequencer: RTL and testbench
=================================

GRID_SEQUENCER -- requirements
Module: grid_sequencer

Interface
REQ-001 Parameter GRID_CELLS, default 25: number of cells shifted in during one load; must be >= 1.
REQ-002 Parameter STEP_PERIOD, default 4: cycles between generation pulses in free-run; must be >= 1.
REQ-003 Parameter GEN_WIDTH, default 16: width of the generation counter and max_gens.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_start  input  1  request to begin a serial grid load.
REQ-007 bit_valid  input  1  serial bit offered on bit_data.
REQ-008 bit_data  input  1  serial cell value.
REQ-009 bit_ready  output  1  sequencer accepts a bit this cycle.
REQ-010 run_start  input  1  begin free-running generations.
REQ-011 run_stop  input  1  pause free-running.
REQ-012 step_req  input  1  advance exactly one generation while paused.
REQ-013 max_gens  input  GEN_WIDTH  generation limit; 0 means unlimited.
REQ-014 load_mode  output  1  registered shift-enable to grid memories.
REQ-015 serial_out  output  1  registered serial bit to grid memories.
REQ-016 run_mode  output  1  registered parallel-load (next generation) enable to grid memories.
REQ-017 gen_count  output  GEN_WIDTH  generations applied since last load.
REQ-018 state  output  3  encoded FSM state: IDLE=0, LOAD=1, LOADED=2, RUN=3, DONE=4.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, LOADED, RUN, DONE, with the transitions below and no others.
REQ-020 load_start in IDLE, LOADED or DONE SHALL enter LOAD and clear gen_count and the bit counter; load_start in LOAD or RUN SHALL be ignored.
REQ-021 bit_ready SHALL be 1 exactly when state is LOAD, combinationally from state.
REQ-022 A bit is accepted on an edge where bit_valid and bit_ready are both 1; on the following cycle load_mode SHALL be 1 and serial_out SHALL equal the accepted bit, for exactly one cycle per accepted bit.
REQ-023 load_mode SHALL be 0 in every cycle not following an accepted bit; serial_out SHALL hold its last value when load_mode is 0.
REQ-024 On acceptance of bit number GRID_CELLS, the FSM SHALL enter LOADED on that same edge; further bit_valid SHALL NOT be accepted.
REQ-025 run_start in LOADED SHALL enter RUN and reset the period counter to 0; run_start elsewhere SHALL be ignored.
REQ-026 In RUN, the period counter SHALL count 0..STEP_PERIOD-1 and wrap; on the edge where it wraps, run_mode SHALL be 1 for the next cycle only and gen_count SHALL increment.
REQ-027 The first run_mode pulse SHALL occur STEP_PERIOD cycles after the edge that enters RUN.
REQ-028 run_stop in RUN SHALL enter LOADED, preserving gen_count; if run_stop coincides with a wrap edge, the pulse and increment SHALL still occur.
REQ-029 step_req in LOADED SHALL produce one run_mode pulse on the next cycle and increment gen_count, staying in LOADED; step_req in other states SHALL be ignored.
REQ-030 When max_gens != 0 and an increment makes gen_count equal to max_gens, the FSM SHALL enter DONE on that edge; a step_req reaching max_gens SHALL also enter DONE.
REQ-031 In DONE, run_mode and load_mode SHALL stay 0; only load_start leaves DONE.
REQ-032 gen_count SHALL saturate at all-ones when max_gens is 0.
REQ-033 load_mode and run_mode SHALL never be 1 in the same cycle.
REQ-034 Simultaneous run_start and load_start in LOADED: load_start SHALL win.

Reset
REQ-035 reset SHALL immediately force state IDLE, load_mode=0, run_mode=0, serial_out=0, gen_count=0, bit and period counters 0, regardless of clk.
REQ-036 reset asserted mid-LOAD or mid-RUN SHALL abort the operation with no further load_mode or run_mode pulse after deassertion.

Verification (GRID_CELLS=5, STEP_PERIOD=4, GEN_WIDTH=16)
REQ-037 Load: load_start, then bits 1,0,0,1,1 with bit_valid held -> five single-cycle load_mode pulses carrying 1,0,0,1,1; state LOADED after fifth acceptance; bit_ready 0 afterward.
REQ-038 Gapped load: bit_valid toggled every other cycle -> load_mode pulses only after accepted bits, still exactly 5 pulses.
REQ-039 Free-run: max_gens=3, run_start -> run_mode pulses at cycles 4, 8, 12 after entry; gen_count 1,2,3; state DONE; no further pulses over 20 cycles.
REQ-040 Pause/step: max_gens=0, run_start, run_stop after 1 pulse -> LOADED, gen_count=1; step_req -> one pulse, gen_count=2.
REQ-041 Ignored inputs: load_start during RUN and step_req during RUN -> no state change, pulse schedule unchanged; run_mode and load_mode never both 1.
REQ-042 Reset mid-run: assert reset between pulses -> outputs 0 and state IDLE before the next clk edge; gen_count=0.

Source files
------------

// File: rtl/grid_sequencer.sv
// grid_sequencer
//   Controls a cellular-automaton grid. It shifts a serial bit stream into the
//   grid memories, then steps generations. It can free-run on a fixed period or
//   advance one step at a time while paused.
//
// Ports
//   clk, reset          : system clock; asynchronous active-high reset
//   load_start          : begin a serial load of GRID_CELLS bits
//   bit_valid/bit_data  : serial bit offer; bit_ready accepts it (only in LOAD)
//   run_start/run_stop  : start / pause free-running generations
//   step_req            : single generation step while paused (LOADED)
//   max_gens            : generation limit, 0 = unlimited
//   load_mode           : registered shift-enable, one cycle per accepted bit
//   serial_out          : registered serial bit, held when load_mode is 0
//   run_mode            : registered one-cycle next-generation enable
//   gen_count           : generations applied since the last load
//   state               : IDLE=0, LOAD=1, LOADED=2, RUN=3, DONE=4
module grid_sequencer #(
  parameter int GRID_CELLS  = 25,
  parameter int STEP_PERIOD = 4,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic                 bit_ready,
  input  logic                 run_start,
  input  logic                 run_stop,
  input  logic                 step_req,
  input  logic [GEN_WIDTH-1:0] max_gens,
  output logic                 load_mode,
  output logic                 serial_out,
  output logic                 run_mode,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic [2:0]           state
);

  localparam int BIT_W = $clog2(GRID_CELLS + 1);
  localparam int PER_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOADED = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             cur_state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PER_W-1:0]   period_cnt;
  logic [GEN_WIDTH-1:0] gen_next;
  logic               hit_max;
  logic               last_bit;
  logic               wrap;

  assign state     = cur_state;
  assign bit_ready = (cur_state == ST_LOAD);

  // The counter sticks at all-ones instead of wrapping back to zero.
  assign gen_next = (gen_count == '1) ? gen_count : gen_count + 1'b1;
  assign hit_max  = (max_gens != '0) && (gen_next == max_gens);
  assign last_bit = (bit_cnt == BIT_W'(GRID_CELLS - 1));
  assign wrap     = (period_cnt == PER_W'(STEP_PERIOD - 1));

  // NOTE: every register, the state included, goes to a known value on the
  // asynchronous reset, so an aborted load or run leaves no pulse pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_IDLE;
      bit_cnt    <= '0;
      period_cnt <= '0;
      gen_count  <= '0;
      load_mode  <= 1'b0;
      serial_out <= 1'b0;
      run_mode   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make both enables single-cycle pulses; a
      // later assignment in the same block overrides them for this edge only.
      load_mode <= 1'b0;
      run_mode  <= 1'b0;

      case (cur_state)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            cur_state <= ST_LOAD;
            gen_count <= '0;
            bit_cnt   <= '0;
          end
        end

        ST_LOAD: begin
          if (bit_valid) begin
            load_mode  <= 1'b1;
            serial_out <= bit_data;
            bit_cnt    <= bit_cnt + 1'b1;
            if (last_bit) cur_state <= ST_LOADED;
          end
        end

        ST_LOADED: begin
          // load_start takes priority over run_start and step_req.
          if (load_start) begin
            cur_state <= ST_LOAD;
            gen_count <= '0;
            bit_cnt   <= '0;
          end else if (run_start) begin
            cur_state  <= ST_RUN;
            period_cnt <= '0;
          end else if (step_req) begin
            run_mode  <= 1'b1;
            gen_count <= gen_next;
            if (hit_max) cur_state <= ST_DONE;
          end
        end

        ST_RUN: begin
          if (wrap) begin
            // A stop on the wrap edge still lets this generation through.
            period_cnt <= '0;
            run_mode   <= 1'b1;
            gen_count  <= gen_next;
            if (hit_max)       cur_state <= ST_DONE;
            else if (run_stop) cur_state <= ST_LOADED;
          end else begin
            period_cnt <= period_cnt + 1'b1;
            if (run_stop) cur_state <= ST_LOADED;
          end
        end

        default: cur_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_sequencer.sv
// tb_grid_sequencer
//   Randomized bench for grid_sequencer (GRID_CELLS=5, STEP_PERIOD=4).
//   The expected results come from a behavioural model. For a load, the model
//   tracks the count of accepted bits and the last accepted bit. For a run
//   started at gen g0, the pulses fall on cycles t = k*P, and the count is
//   g0 + min(t/P, limit).
module tb_grid_sequencer;

  localparam int N  = 5;
  localparam int P  = 4;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, bit_valid, bit_data, bit_ready;
  logic          run_start, run_stop, step_req;
  logic [GW-1:0] max_gens;
  logic          load_mode, serial_out, run_mode;
  logic [GW-1:0] gen_count;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  bit m_serial = 1'b0;   // model: last bit shifted out
  int m_gen    = 0;      // model: generation count

  grid_sequencer #(.GRID_CELLS(N), .STEP_PERIOD(P), .GEN_WIDTH(GW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .bit_valid(bit_valid),
    .bit_data(bit_data), .bit_ready(bit_ready), .run_start(run_start),
    .run_stop(run_stop), .step_req(step_req), .max_gens(max_gens),
    .load_mode(load_mode), .serial_out(serial_out), .run_mode(run_mode),
    .gen_count(gen_count), .state(state)
  );

  always #5 clk = ~clk;

  // The two enables must never be high together.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (load_mode && run_mode) begin
        errors++;
        $display("FAIL exclusive_modes: load_mode=%0b run_mode=%0b, required not both 1", load_mode, run_mode);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    load_start = 0; bit_valid = 0; bit_data = 0;
    run_start = 0; run_stop = 0; step_req = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL %s_state: got %0d required 0", tag, state); end
    checks++; if (load_mode !== 1'b0 || run_mode !== 1'b0) begin errors++; $display("FAIL %s_modes: got load=%0b run=%0b required 0/0", tag, load_mode, run_mode); end
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL %s_serial: got %0b required 0", tag, serial_out); end
    checks++; if (gen_count !== '0) begin errors++; $display("FAIL %s_gen: got %0d required 0", tag, gen_count); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL %s_ready: got %0b required 0", tag, bit_ready); end
  endtask

  task automatic test_reset;
    clear_inputs();
    max_gens = '0;
    reset = 1;
    #3;   // before the first clock edge: asynchronous reset must already hold
    check_idle_zero("reset_async");
    tick(); tick();
    reset = 0;
    tick();
    check_idle_zero("reset_release");
    m_serial = 0; m_gen = 0;
  endtask

  // mode 0: pattern 1,0,0,1,1 with bit_valid held
  // mode 1: random bits, bit_valid toggled every other cycle
  // mode 2: random bits and random bit_valid, plus noise on inputs LOAD ignores
  task automatic load_grid(input string tag, input int mode);
    bit pat [N];
    bit v;
    int acc;
    for (int i = 0; i < N; i++) pat[i] = (mode == 0) ? ((i == 0) || (i >= 3)) : 1'($urandom_range(0, 1));
    load_start = 1;
    tick();
    load_start = 0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL %s_enter_load: state %0d required 1", tag, state); end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_hi: got %0b required 1", tag, bit_ready); end
    checks++; if (gen_count !== '0) begin errors++; $display("FAIL %s_gen_clear: got %0d required 0", tag, gen_count); end
    checks++; if (load_mode !== 1'b0) begin errors++; $display("FAIL %s_no_early_shift: got %0b required 0", tag, load_mode); end
    m_gen = 0;
    acc = 0;
    for (int cyc = 0; cyc < 80 && acc < N; cyc++) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      bit_valid = v;
      bit_data  = v ? pat[acc] : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        load_start = 1'($urandom_range(0, 1));
        run_start  = 1'($urandom_range(0, 1));
        step_req   = 1'($urandom_range(0, 1));
      end
      tick();
      if (v) begin
        m_serial = pat[acc];
        acc++;
      end
      checks++; if (load_mode !== v) begin errors++; $display("FAIL %s_load_mode: cycle %0d got %0b required %0b", tag, cyc, load_mode, v); end
      checks++; if (serial_out !== m_serial) begin errors++; $display("FAIL %s_serial: cycle %0d got %0b required %0b", tag, cyc, serial_out, m_serial); end
      checks++; if (state !== ((acc == N) ? 3'd2 : 3'd1)) begin errors++; $display("FAIL %s_state: cycle %0d got %0d required %0d", tag, cyc, state, (acc == N) ? 2 : 1); end
      checks++; if (bit_ready !== (acc < N)) begin errors++; $display("FAIL %s_ready: cycle %0d got %0b required %0b", tag, cyc, bit_ready, acc < N); end
    end
    clear_inputs();
    checks++; if (acc != N) begin errors++; $display("FAIL %s_timeout: accepted %0d bits, required %0d", tag, acc, N); end
    // Offers after the grid is full must be refused.
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1; bit_data = 1'($urandom_range(0, 1));
      tick();
      checks++; if (load_mode !== 1'b0 || state !== 3'd2 || serial_out !== m_serial || bit_ready !== 1'b0)
        begin errors++; $display("FAIL %s_extra_bits: load=%0b state=%0d serial=%0b ready=%0b required 0/2/%0b/0", tag, load_mode, state, serial_out, bit_ready, m_serial); end
    end
    clear_inputs();
  endtask

  // Starts a free run from LOADED and checks the pulse schedule from arithmetic.
  task automatic run_free(input string tag, input int max_g, input int cycles, input bit noise);
    int g0, limit, q, pulses;
    bit exp_pulse, done;
    max_gens = GW'(max_g);
    run_start = 1;
    tick();
    run_start = 0;
    checks++; if (state !== 3'd3 || run_mode !== 1'b0) begin errors++; $display("FAIL %s_enter_run: state %0d run_mode %0b required 3/0", tag, state, run_mode); end
    g0 = m_gen;
    limit = (max_g != 0) ? (max_g - g0) : 32'h3fff_ffff;
    done = 0;
    for (int t = 1; t <= cycles; t++) begin
      if (noise && !done) begin
        load_start = 1'($urandom_range(0, 1));
        step_req   = 1'($urandom_range(0, 1));
        run_start  = 1'($urandom_range(0, 1));
      end else begin
        clear_inputs();
      end
      tick();
      q = t / P;
      pulses = (q < limit) ? q : limit;
      exp_pulse = (t % P == 0) && (q <= limit);
      done = (max_g != 0) && (pulses == limit);
      checks++; if (run_mode !== exp_pulse) begin errors++; $display("FAIL %s_run_mode: t=%0d got %0b required %0b", tag, t, run_mode, exp_pulse); end
      checks++; if (gen_count !== GW'(g0 + pulses)) begin errors++; $display("FAIL %s_gen: t=%0d got %0d required %0d", tag, t, gen_count, g0 + pulses); end
      checks++; if (state !== (done ? 3'd4 : 3'd3)) begin errors++; $display("FAIL %s_state: t=%0d got %0d required %0d", tag, t, state, done ? 4 : 3); end
      checks++; if (load_mode !== 1'b0 || serial_out !== m_serial) begin errors++; $display("FAIL %s_load_quiet: t=%0d load=%0b serial=%0b required 0/%0b", tag, t, load_mode, serial_out, m_serial); end
    end
    clear_inputs();
    q = cycles / P;
    m_gen = g0 + ((q < limit) ? q : limit);
  endtask

  task automatic test_load;
    load_grid("load", 0);
  endtask

  task automatic test_gapped_load;
    load_grid("gapped", 1);
  endtask

  task automatic test_free_run;
    load_grid("fr_load", 2);
    run_free("free_run", 3, 32, 0);   // pulses at 4, 8, 12 then 20 quiet cycles
  endtask

  task automatic test_pause_step;
    load_grid("ps_load", 1);
    max_gens = '0;
    run_start = 1; tick(); run_start = 0;
    for (int t = 1; t <= P; t++) begin
      tick();
      checks++; if (run_mode !== (t == P)) begin errors++; $display("FAIL ps_first_pulse: t=%0d got %0b required %0b", t, run_mode, t == P); end
    end
    run_stop = 1; tick(); run_stop = 0;
    checks++; if (state !== 3'd2 || gen_count !== GW'(1) || run_mode !== 1'b0) begin errors++; $display("FAIL ps_stop: state %0d gen %0d run %0b required 2/1/0", state, gen_count, run_mode); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (run_mode !== 1'b0 || state !== 3'd2 || gen_count !== GW'(1)) begin errors++; $display("FAIL ps_paused: state %0d gen %0d run %0b required 2/1/0", state, gen_count, run_mode); end
    end
    step_req = 1; tick(); step_req = 0;
    checks++; if (run_mode !== 1'b1 || gen_count !== GW'(2) || state !== 3'd2) begin errors++; $display("FAIL ps_step: state %0d gen %0d run %0b required 2/2/1", state, gen_count, run_mode); end
    tick();
    checks++; if (run_mode !== 1'b0 || gen_count !== GW'(2)) begin errors++; $display("FAIL ps_step_single: gen %0d run %0b required 2/0", gen_count, run_mode); end
    // Stop on the wrap edge: the pulse and increment still happen.
    run_start = 1; tick(); run_start = 0;
    for (int t = 1; t < P; t++) tick();
    run_stop = 1; tick(); run_stop = 0;
    checks++; if (run_mode !== 1'b1 || gen_count !== GW'(3) || state !== 3'd2) begin errors++; $display("FAIL ps_stop_on_wrap: state %0d gen %0d run %0b required 2/3/1", state, gen_count, run_mode); end
    tick();
    checks++; if (run_mode !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL ps_after_wrap_stop: state %0d run %0b required 2/0", state, run_mode); end
    // A step that reaches max_gens finishes the run.
    max_gens = GW'(4);
    step_req = 1; tick(); step_req = 0;
    checks++; if (run_mode !== 1'b1 || gen_count !== GW'(4) || state !== 3'd4) begin errors++; $display("FAIL ps_step_to_done: state %0d gen %0d run %0b required 4/4/1", state, gen_count, run_mode); end
    for (int i = 0; i < 5; i++) begin
      step_req = 1'($urandom_range(0, 1)); run_start = 1'($urandom_range(0, 1)); bit_valid = 1;
      tick();
      checks++; if (state !== 3'd4 || run_mode !== 1'b0 || load_mode !== 1'b0 || gen_count !== GW'(4)) begin errors++; $display("FAIL ps_done_hold: state %0d run %0b load %0b gen %0d required 4/0/0/4", state, run_mode, load_mode, gen_count); end
    end
    clear_inputs();
    m_gen = 4;
  endtask

  task automatic test_simultaneous;
    load_grid("sim_load", 0);
    load_start = 1; run_start = 1;
    tick();
    clear_inputs();
    checks++; if (state !== 3'd1 || run_mode !== 1'b0) begin errors++; $display("FAIL sim_load_wins: state %0d run %0b required 1/0", state, run_mode); end
    load_grid("sim_reload", 1);
  endtask

  task automatic test_ignored;
    load_grid("ign_load", 2);
    run_free("ignored", 0, 24, 1);
    run_stop = 1; tick(); clear_inputs();
    m_gen = 24 / P;
  endtask

  task automatic test_random_runs;
    for (int r = 0; r < 3; r++) begin
      int mg;
      load_grid("rnd_load", 2);
      mg = $urandom_range(1, 5);
      run_free("rnd_run", mg, mg * P + 8, 1);
    end
  endtask

  task automatic test_reset_mid;
    load_grid("rm_load", 0);
    max_gens = '0;
    run_start = 1; tick(); run_start = 0;
    for (int t = 1; t <= 6; t++) tick();
    reset = 1;
    #2;   // still well before the next clock edge
    check_idle_zero("reset_mid_run");
    tick();
    reset = 0;
    m_serial = 0; m_gen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (run_mode !== 1'b0 || load_mode !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL rm_run_quiet: state %0d run %0b load %0b required 0/0/0", state, run_mode, load_mode); end
    end
    // Abort a load part-way through while bits keep coming.
    load_start = 1; tick(); load_start = 0;
    bit_valid = 1; bit_data = 1;
    tick(); tick();
    reset = 1;
    #2;
    check_idle_zero("reset_mid_load");
    tick();
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (load_mode !== 1'b0 || state !== 3'd0 || serial_out !== 1'b0) begin errors++; $display("FAIL rm_load_quiet: state %0d load %0b serial %0b required 0/0/0", state, load_mode, serial_out); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_gapped_load();
    test_free_run();
    test_pause_step();
    test_simultaneous();
    test_ignored();
    test_random_runs();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
